// File: rtl/om_seq_ctrl_if.sv
// rtl/om_seq_ctrl_if.sv - digit-stream and datapath signal bundle for the online multiplier sequencer
interface om_seq_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic [1:0]   x_dig;
    logic [1:0]   y_dig;
    logic         dig_valid;
    logic         dig_ready;
    logic [1:0]   dp_x;
    logic [1:0]   dp_y;
    logic [N:0]   dp_xprefix;
    logic [N:0]   dp_yprefix;
    logic         dp_en;
    logic         dp_clr;
    logic [1:0]   dp_z;
    logic [1:0]   z_dig;
    logic         z_valid;
    logic         busy;
    logic         done;

    modport master (
        output start, x_dig, y_dig, dig_valid, dp_z,
        input  dig_ready, dp_x, dp_y, dp_xprefix, dp_yprefix, dp_en, dp_clr,
        input  z_dig, z_valid, busy, done
    );

    modport slave (
        input  start, x_dig, y_dig, dig_valid, dp_z,
        output dig_ready, dp_x, dp_y, dp_xprefix, dp_yprefix, dp_en, dp_clr,
        output z_dig, z_valid, busy, done
    );
endinterface

// File: rtl/om_seq_ctrl.sv
// rtl/om_seq_ctrl.sv - step sequencer and prefix accumulator for the radix-2 online multiplier
module om_seq_ctrl #(
    parameter int N     = 8,
    parameter int DELTA = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    om_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(N + DELTA + 1);
    localparam logic [CW-1:0] LAST_RUN  = CW'(N - 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N + DELTA - 1);
    localparam logic [CW-1:0] FIRST_Z   = CW'(DELTA);

    typedef enum logic [2:0] {IDLE, CLR, RUN, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] step_q, step_d;
    logic [N:0]    xreg_q, yreg_q;
    logic [1:0]    z_dig_q;
    logic          z_valid_q;

    logic [1:0]    dx, dy;
    logic [1:0]    dp_x_c, dp_y_c;
    logic          dp_en_c, dp_clr_c, step_run, emit_z;
    logic [N:0]    wt, x_term, y_term, yprefix;

    // The redundant zero encoding 2'b11 is folded to 2'b00 before anything sees it
    assign dx = (bus.x_dig == 2'b11) ? 2'b00 : bus.x_dig;
    assign dy = (bus.y_dig == 2'b11) ? 2'b00 : bus.y_dig;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        step_run = 1'b0;
        dp_en_c  = 1'b0;
        dp_clr_c = 1'b0;
        dp_x_c   = 2'b00;
        dp_y_c   = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = CLR;
            end
            CLR: begin
                dp_clr_c = 1'b1;
                step_d   = '0;
                state_d  = RUN;
            end
            RUN: begin
                if (bus.dig_valid) begin
                    step_run = 1'b1;
                    dp_en_c  = 1'b1;
                    dp_x_c   = dx;
                    dp_y_c   = dy;
                    step_d   = step_q + CW'(1);
                    if (step_q == LAST_RUN) state_d = FLUSH;
                end
            end
            FLUSH: begin
                dp_en_c = 1'b1;
                step_d  = step_q + CW'(1);
                if (step_q == LAST_STEP) state_d = DONE;
            end
            DONE: begin
                step_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Step c carries weight 2^-(c+1), i.e. fraction bit N-1-c of the prefix
    always_comb begin
        wt     = (N + 1)'(1) << (LAST_RUN - step_q);
        x_term = '0;
        y_term = '0;
        if (dp_x_c == 2'b10)      x_term = wt;
        else if (dp_x_c == 2'b01) x_term = -wt;
        if (dp_y_c == 2'b10)      y_term = wt;
        else if (dp_y_c == 2'b01) y_term = -wt;
        yprefix = yreg_q + y_term;
        emit_z  = dp_en_c && (step_q >= FIRST_Z);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= '0;
            xreg_q    <= '0;
            yreg_q    <= '0;
            z_dig_q   <= 2'b00;
            z_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (dp_clr_c) begin
                xreg_q <= '0;
                yreg_q <= '0;
            end else if (step_run) begin
                xreg_q <= xreg_q + x_term;
                yreg_q <= yprefix;
            end
            z_valid_q <= emit_z;
            z_dig_q   <= emit_z ? bus.dp_z : 2'b00;
        end
    end

    assign bus.dig_ready  = (state_q == RUN);
    assign bus.busy       = (state_q == CLR) || (state_q == RUN) || (state_q == FLUSH);
    assign bus.done       = (state_q == DONE);
    assign bus.dp_x       = dp_x_c;
    assign bus.dp_y       = dp_y_c;
    assign bus.dp_en      = dp_en_c;
    assign bus.dp_clr     = dp_clr_c;
    assign bus.dp_xprefix = xreg_q;
    assign bus.dp_yprefix = yprefix;
    assign bus.z_dig      = z_dig_q;
    assign bus.z_valid    = z_valid_q;
endmodule

// File: tb/tb_om_seq_ctrl.sv
// tb/tb_om_seq_ctrl.sv - directed bench for om_seq_ctrl with a behavioural online-multiplier datapath
module tb_om_seq_ctrl;
    localparam int N     = 8;
    localparam int DELTA = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    om_seq_ctrl_if #(.N(N)) bus ();

    om_seq_ctrl #(.N(N), .DELTA(DELTA)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int dval(input logic [1:0] d);
        return (d == 2'b10) ? 1 : (d == 2'b01) ? -1 : 0;
    endfunction

    // Residual recurrence in units of 2^-(N+DELTA); selection is held off during warm-up
    int w_res = 0;
    int dp_steps = 0;
    int v_res, z_sel;
    always_comb begin
        v_res = 2 * w_res
              + dval(bus.dp_x) * int'($signed(bus.dp_yprefix))
              + dval(bus.dp_y) * int'($signed(bus.dp_xprefix));
        z_sel = 0;
        if (dp_steps >= DELTA) begin
            if (v_res >= 1024)       z_sel = 1;
            else if (v_res <= -1024) z_sel = -1;
        end
        bus.dp_z = (z_sel == 1) ? 2'b10 : (z_sel == -1) ? 2'b01 : 2'b00;
    end

    always @(posedge clk) begin
        if (bus.dp_clr) begin
            w_res    <= 0;
            dp_steps <= 0;
        end else if (bus.dp_en) begin
            w_res    <= v_res - z_sel * 2048;
            dp_steps <= dp_steps + 1;
        end
    end

    logic [1:0]  xs [N];
    logic [1:0]  ys [N];
    int stall_after, stall_len, start_pulse_cyc, reset_cyc;
    int clr_cyc, first_z, last_z, done_cyc, done_cnt, z_cnt, z_sum, gap_bad;
    logic [15:0] z_word;
    logic [N:0]  xpre [N];
    logic [N:0]  ypre [N];
    logic [1:0]  dpx  [N];
    logic [N:0]  gap_x0, gap_y0;

    task automatic load(input logic [15:0] xv, input logic [15:0] yv,
                        input int sa, input int sl, input int sp, input int rc);
        for (int i = 0; i < N; i++) begin
            xs[i] = xv[15 - 2*i -: 2];
            ys[i] = yv[15 - 2*i -: 2];
        end
        stall_after = sa;
        stall_len = sl;
        start_pulse_cyc = sp;
        reset_cyc = rc;
    endtask

    task automatic run_op(input int max_cyc);
        int idx = 0;
        int stall_left = 0;
        int gap_seen = 0;
        clr_cyc = -1; first_z = -1; last_z = -1; done_cyc = -1;
        done_cnt = 0; z_cnt = 0; z_sum = 0; gap_bad = 0; z_word = '0;
        gap_x0 = '0; gap_y0 = '0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            bus.start = (cyc == 0) || (cyc == start_pulse_cyc);
            rst_n = (cyc != reset_cyc);
            if (bus.dig_ready && idx < N && stall_left == 0) begin
                bus.dig_valid = 1'b1;
                bus.x_dig = xs[idx];
                bus.y_dig = ys[idx];
            end else begin
                bus.dig_valid = 1'b0;
                bus.x_dig = 2'b10;
                bus.y_dig = 2'b01;
            end
            #1;
            if (cyc == reset_cyc)
                check("rst_mid_outs", {bus.dig_ready, bus.dp_x, bus.dp_y, bus.dp_xprefix,
                      bus.dp_yprefix, bus.dp_en, bus.dp_clr, bus.z_dig, bus.z_valid,
                      bus.busy, bus.done}, 0);
            if (bus.dp_clr) clr_cyc = cyc;
            if (bus.z_valid) begin
                z_cnt++;
                if (first_z < 0) first_z = cyc;
                last_z = cyc;
                if (z_cnt <= N) z_sum += dval(bus.z_dig) * (1 << (N - z_cnt));
                z_word = {z_word[13:0], bus.z_dig};
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.dig_valid && bus.dig_ready) begin
                xpre[idx] = bus.dp_xprefix;
                ypre[idx] = bus.dp_yprefix;
                dpx[idx] = bus.dp_x;
                if (idx == stall_after) stall_left = stall_len;
                idx++;
            end else if (stall_left > 0) begin
                if (gap_seen == 0) begin
                    gap_x0 = bus.dp_xprefix;
                    gap_y0 = bus.dp_yprefix;
                end
                gap_seen++;
                if (bus.dp_en || bus.dp_x != 2'b00 || bus.dp_y != 2'b00 ||
                    bus.dp_xprefix != gap_x0 || bus.dp_yprefix != gap_y0)
                    gap_bad++;
                stall_left--;
            end
        end
        bus.start = 1'b0;
        bus.dig_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.dig_valid = 1'b0;
        bus.x_dig = 2'b00;
        bus.y_dig = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", {bus.dig_ready, bus.dp_x, bus.dp_y, bus.dp_xprefix, bus.dp_yprefix,
              bus.dp_en, bus.dp_clr, bus.z_dig, bus.z_valid, bus.busy, bus.done}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_outs", {bus.dig_ready, bus.busy, bus.done, bus.z_valid, bus.dp_en}, 0);

        // 0.5 * 0.5 -> digits +1,-1,0,... summing to 0.25
        load(16'h8000, 16'h8000, -1, 0, -1, -1);
        run_op(20);
        check("basic_clr_cyc", clr_cyc, 1);
        check("basic_first_z", first_z, 6);
        check("basic_last_z", last_z, 13);
        check("basic_done_cyc", done_cyc, 13);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_z_cnt", z_cnt, 8);
        check("basic_z_sum", z_sum, 64);
        check("basic_z_word", z_word, 16'h9000);

        // x = 0.25 via +1,-1 ; y = -0.5
        load(16'h9000, 16'h4000, -1, 0, -1, -1);
        run_op(20);
        check("pre_x0", xpre[0], 9'h000);
        check("pre_x1", xpre[1], 9'h080);
        check("pre_x2", xpre[2], 9'h040);
        check("pre_x7", xpre[7], 9'h040);
        check("pre_y0", ypre[0], 9'h180);
        check("pre_z_sum", z_sum, -32);

        load(16'h8000, 16'h8000, 2, 3, -1, -1);
        run_op(24);
        check("stall_gap_bad", gap_bad, 0);
        check("stall_gap_x", gap_x0, 9'h080);
        check("stall_gap_y", gap_y0, 9'h080);
        check("stall_done_cyc", done_cyc, 16);
        check("stall_last_z", last_z, 16);
        check("stall_z_word", z_word, 16'h9000);

        // x = +1,11,0... still 0.5; start pulsed mid-RUN
        load(16'hB000, 16'h8000, -1, 0, 5, -1);
        run_op(20);
        check("illegal_dpx", dpx[1], 2'b00);
        check("illegal_xpre2", xpre[2], 9'h080);
        check("busy_start_done", done_cyc, 13);
        check("busy_start_cnt", done_cnt, 1);
        check("illegal_z_sum", z_sum, 64);

        load(16'h8000, 16'h8000, -1, 0, -1, 11);
        run_op(20);
        check("rst_mid_no_done", done_cnt, 0);
        load(16'h8000, 16'h8000, -1, 0, -1, -1);
        run_op(20);
        check("rst_rerun_done", done_cyc, 13);
        check("rst_rerun_z_sum", z_sum, 64);

        // 0.75 * -0.5 = -0.375
        load(16'hA000, 16'h4000, -1, 0, -1, -1);
        run_op(20);
        check("neg_z_sum", z_sum, -96);
        check("neg_z_cnt", z_cnt, 8);
        check("neg_done_cnt", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
